// File: rtl/fetch_unit.sv
// fetch_unit: program counter, run/halt sequencer and performance counters
// for the 9-bit single-cycle core. The ROM is read combinationally at the
// registered PC; the fetched word is forwarded to the decoder while running.
module fetch_unit #(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned START_ADDR = 0,
  parameter logic [8:0]  HALT_INSTR = 9'h1FF,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stall,
  input  logic             Jump,
  input  logic             BranchEn,
  input  logic             Taken,
  input  logic [PC_W-1:0]  Target,
  input  logic [8:0]       InstrIn,
  output logic [PC_W-1:0]  InstrAddr,
  output logic [8:0]       Instruction,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCount,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [PC_W-1:0]  START_PC = PC_W'(START_ADDR);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PC_W-1:0]  PC_ONE   = PC_W'(1);

  state_t           state, state_nxt;
  logic [PC_W-1:0]  pc, pc_nxt;
  logic [CNT_W-1:0] cyc_cnt, cyc_cnt_nxt;
  logic [CNT_W-1:0] ins_cnt, ins_cnt_nxt;
  logic             is_halt;

  assign is_halt = (InstrIn == HALT_INSTR);

  // Next-state, next-PC and counter update rules for each sequencer state.
  always_comb begin
    // NOTE: every signal gets a hold value first so no path through the
    // case leaves one unassigned, which would infer a latch.
    state_nxt   = state;
    pc_nxt      = pc;
    cyc_cnt_nxt = cyc_cnt;
    ins_cnt_nxt = ins_cnt;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          state_nxt   = ST_RUN;
          pc_nxt      = START_PC;
          cyc_cnt_nxt = '0;
          ins_cnt_nxt = '0;
        end
      end
      ST_RUN: begin
        // Every RUN cycle counts, stalled and halting ones included.
        if (cyc_cnt != '1) cyc_cnt_nxt = cyc_cnt + CNT_ONE;
        if (!Stall) begin
          if (is_halt) begin
            // Halt word is not retired; PC stays on it.
            state_nxt = ST_DONE;
          end else begin
            if (ins_cnt != '1) ins_cnt_nxt = ins_cnt + CNT_ONE;
            if (Jump || (BranchEn && Taken)) pc_nxt = Target;
            else                             pc_nxt = pc + PC_ONE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, PC and counter registers with synchronous reset.
  always_ff @(posedge Clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (Reset) begin
      state   <= ST_IDLE;
      pc      <= START_PC;
      cyc_cnt <= '0;
      ins_cnt <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      cyc_cnt <= cyc_cnt_nxt;
      ins_cnt <= ins_cnt_nxt;
    end
  end

  assign Running     = (state == ST_RUN);
  assign Done        = (state == ST_DONE);
  assign InstrAddr   = pc;
  assign Instruction = Running ? InstrIn : 9'h000;
  assign CycleCount  = cyc_cnt;
  assign InstrCount  = ins_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus for fetch_unit. Two instances share the
// control inputs: one with 16-bit counters, one with 4-bit counters to
// exercise saturation. A behavioural model tracks mode, PC and raw
// (unbounded) counts; the compare process checks both instances against it
// on every falling edge, and literal checks pin the model at key points.
module tb_fetch_unit;

  localparam int PC_W = 10;

  logic            Clk;
  logic            Reset, Start, Stall, Jump, BranchEn, Taken;
  logic [PC_W-1:0] Target;
  logic [8:0]      rom [0:1023];

  logic [PC_W-1:0] addr_a, addr_b;
  logic [8:0]      in_a, in_b, instr_a, instr_b;
  logic            run_a, run_b, done_a, done_b;
  logic [15:0]     cc_a, ic_a;
  logic [3:0]      cc_b, ic_b;

  int n_vec = 0;
  int n_err = 0;

  assign in_a = rom[addr_a];
  assign in_b = rom[addr_b];

  fetch_unit #(.PC_W(PC_W), .START_ADDR(0), .HALT_INSTR(9'h1FF), .CNT_W(16)) dut_a (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Jump(Jump),
    .BranchEn(BranchEn), .Taken(Taken), .Target(Target), .InstrIn(in_a),
    .InstrAddr(addr_a), .Instruction(instr_a), .Running(run_a), .Done(done_a),
    .CycleCount(cc_a), .InstrCount(ic_a)
  );

  fetch_unit #(.PC_W(PC_W), .START_ADDR(0), .HALT_INSTR(9'h1FF), .CNT_W(4)) dut_b (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Jump(Jump),
    .BranchEn(BranchEn), .Taken(Taken), .Target(Target), .InstrIn(in_b),
    .InstrAddr(addr_b), .Instruction(instr_b), .Running(run_b), .Done(done_b),
    .CycleCount(cc_b), .InstrCount(ic_b)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 running, 2 done. Counts are unbounded integers and are
  // clipped to each instance's counter range only when compared.
  int m_mode, m_pc, m_cyc, m_ins;
  bit m_valid = 1'b0;

  always @(posedge Clk) begin
    if (Reset) begin
      m_mode = 0; m_pc = 0; m_cyc = 0; m_ins = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_mode == 1) begin
        m_cyc = m_cyc + 1;
        if (!Stall) begin
          if (rom[m_pc] == 9'h1FF) m_mode = 2;
          else begin
            m_ins = m_ins + 1;
            if (Jump)                   m_pc = int'(Target);
            else if (BranchEn && Taken) m_pc = int'(Target);
            else                        m_pc = (m_pc + 1) % 1024;
          end
        end
      end else if (Start) begin
        m_mode = 1; m_pc = 0; m_cyc = 0; m_ins = 0;
      end
    end
  end

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Compare both instances against the model on every falling edge.
  always @(negedge Clk) begin
    if (m_valid) begin
      check("addr_a",  32'(addr_a),  32'(m_pc));
      check("run_a",   32'(run_a),   32'(m_mode == 1));
      check("done_a",  32'(done_a),  32'(m_mode == 2));
      check("instr_a", 32'(instr_a), (m_mode == 1) ? 32'(rom[m_pc]) : 32'd0);
      check("cyc_a",   32'(cc_a),    32'(sat(m_cyc, 65535)));
      check("ins_a",   32'(ic_a),    32'(sat(m_ins, 65535)));
      check("addr_b",  32'(addr_b),  32'(m_pc));
      check("run_b",   32'(run_b),   32'(m_mode == 1));
      check("done_b",  32'(done_b),  32'(m_mode == 2));
      check("instr_b", 32'(instr_b), (m_mode == 1) ? 32'(rom[m_pc]) : 32'd0);
      check("cyc_b",   32'(cc_b),    32'(sat(m_cyc, 15)));
      check("ins_b",   32'(ic_b),    32'(sat(m_ins, 15)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic edges(input int n);
    repeat (n) @(negedge Clk);
    #1;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    edges(1);
    Start = 1'b0;
  endtask

  task automatic ctl(input logic j, input logic b, input logic t, input int tgt);
    Jump = j; BranchEn = b; Taken = t; Target = PC_W'(tgt);
  endtask

  // Hand-computed expectations on the 16-bit instance.
  task automatic lit(input string tag, input int pc, input int run, input int dn,
                     input int cyc, input int ins);
    check({tag, ".pc"},   32'(addr_a), 32'(pc));
    check({tag, ".run"},  32'(run_a),  32'(run));
    check({tag, ".done"}, 32'(done_a), 32'(dn));
    check({tag, ".cyc"},  32'(cc_a),   32'(cyc));
    check({tag, ".ins"},  32'(ic_a),   32'(ins));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
    Reset = 1'b1; Start = 1'b0; Stall = 1'b0;
    ctl(1'b0, 1'b0, 1'b0, 0);
    edges(2);
    lit("reset", 0, 0, 0, 0, 0);
    check("reset.instr", 32'(instr_a), 32'd0);
    Reset = 1'b0;

    // Idle ignores control inputs other than Start.
    ctl(1'b1, 1'b0, 1'b0, 33);
    edges(2);
    lit("idle", 0, 0, 0, 0, 0);
    ctl(1'b0, 1'b0, 1'b0, 0);

    // Five plain ops then halt at address 5.
    rom[5] = 9'h1FF;
    pulse_start();
    lit("start", 0, 1, 0, 0, 0);
    edges(5);
    lit("at_halt", 5, 1, 0, 5, 5);
    check("halt_word", 32'(instr_a), 32'h1FF);
    edges(1);
    lit("halted", 5, 0, 1, 6, 5);
    edges(2);
    lit("frozen", 5, 0, 1, 6, 5);

    // Restart from DONE, then jumps and branches.
    rom[5] = 9'h000;
    pulse_start();
    lit("restart", 0, 1, 0, 0, 0);
    edges(3);
    ctl(1'b1, 1'b0, 1'b0, 40); edges(1);
    lit("jump40", 40, 1, 0, 4, 4);
    ctl(1'b1, 1'b0, 1'b0, 7);  edges(1);
    ctl(1'b0, 1'b1, 1'b0, 2);  edges(1);
    lit("br_not_taken", 8, 1, 0, 6, 6);
    Start = 1'b1;
    ctl(1'b1, 1'b0, 1'b0, 7);  edges(1);
    Start = 1'b0;
    lit("start_in_run", 7, 1, 0, 7, 7);
    ctl(1'b0, 1'b1, 1'b1, 2);  edges(1);
    lit("br_taken", 2, 1, 0, 8, 8);
    ctl(1'b1, 1'b0, 1'b0, 7);  edges(1);
    ctl(1'b0, 1'b0, 1'b1, 2);  edges(1);
    lit("taken_no_en", 8, 1, 0, 10, 10);
    ctl(1'b1, 1'b1, 1'b0, 30); edges(1);
    lit("jump_and_br", 30, 1, 0, 11, 11);
    ctl(1'b1, 1'b0, 1'b0, 12); edges(1);

    // Stall at 12 for three cycles, with a jump pending underneath.
    Stall = 1'b1;
    ctl(1'b1, 1'b0, 1'b0, 50); edges(3);
    lit("stalled", 12, 1, 0, 15, 12);
    Stall = 1'b0;
    ctl(1'b0, 1'b0, 1'b0, 0);  edges(1);
    lit("unstall", 13, 1, 0, 16, 13);

    // Halt word under stall does not halt until stall drops.
    rom[20] = 9'h1FF;
    ctl(1'b1, 1'b0, 1'b0, 20); edges(1);
    ctl(1'b0, 1'b0, 1'b0, 0);
    Stall = 1'b1; edges(2);
    lit("stalled_halt", 20, 1, 0, 19, 14);
    Stall = 1'b0; edges(1);
    lit("halt_after_stall", 20, 0, 1, 20, 14);
    check("sat4.cyc", 32'(cc_b), 32'd15);
    check("sat4.ins", 32'(ic_b), 32'd14);

    // PC wrap from the top address.
    pulse_start();
    ctl(1'b1, 1'b0, 1'b0, 1023); edges(1);
    ctl(1'b0, 1'b0, 1'b0, 0);    edges(1);
    lit("wrap", 0, 1, 0, 2, 2);

    // Reset together with Start mid-run at PC 9.
    ctl(1'b1, 1'b0, 1'b0, 9); edges(1);
    ctl(1'b0, 1'b0, 1'b0, 0);
    check("pc9", 32'(addr_a), 32'd9);
    Reset = 1'b1; Start = 1'b1; edges(1);
    Reset = 1'b0; Start = 1'b0;
    lit("reset_mid_run", 0, 0, 0, 0, 0);
    rom[3] = 9'h1FF;
    edges(1);
    lit("idle_after_reset", 0, 0, 0, 0, 0);
    pulse_start();
    lit("restart2", 0, 1, 0, 0, 0);
    edges(4);
    lit("halt3", 3, 0, 1, 4, 3);
    edges(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and fetch sequencer for the 9-bit single-cycle core. It sits directly upstream of the instruction decoder. It drives the instruction-ROM address and passes the fetched 9-bit word straight through to the decoder. It consumes the decoder's Jump/BranchEn outputs and the ALU branch flag to choose the next PC. It also owns the run/halt state machine and the performance counters read by the test harness.

## Interface
Parameters:
- PC_W, 10, program counter / ROM address width
- START_ADDR, 0, PC value loaded on reset and on every Start
- HALT_INSTR, 9'h1FF, instruction encoding that terminates the program
- CNT_W, 16, width of cycle and instruction counters

Ports:
- Clk  in  1  core clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- Start  in  1  single-cycle pulse; begins execution from START_ADDR
- Stall  in  1  hold current instruction (PC and InstrCount frozen)
- Jump  in  1  from decoder: unconditional jump this instruction
- BranchEn  in  1  from decoder: instruction is a conditional branch
- Taken  in  1  from ALU: branch condition true (ignored unless BranchEn)
- Target  in  PC_W  absolute target address for jump/taken branch (from target lookup)
- InstrIn  in  9  ROM data for address InstrAddr (combinational ROM read)
- InstrAddr  out  PC_W  current PC, drives ROM address
- Instruction  out  9  InstrIn forwarded to decoder; forced to 9'h000 when not Running
- Running  out  1  FSM in RUN
- Done  out  1  FSM in DONE
- CycleCount  out  CNT_W  cycles spent in RUN
- InstrCount  out  CNT_W  instructions retired (halt excluded)

## Operation
- FSM states: IDLE, RUN, DONE. Encoding is free; outputs are decoded from the state.
- IDLE: entered on Reset. Start moves to RUN. All other inputs are ignored.
- RUN: each non-stalled cycle retires the instruction at PC.
- Next PC priority, highest first:
  - Stall: PC holds.
  - InstrIn == HALT_INSTR: PC holds and the FSM goes to DONE.
  - Jump: PC <= Target.
  - BranchEn && Taken: PC <= Target.
  - Otherwise: PC <= PC + 1.
- If Jump and BranchEn are both asserted (illegal decode), Jump wins.
- PC + 1 wraps modulo 2^PC_W (max address -> 0). There is no error flag.
- Halt check applies only when Stall=0. A stalled HALT_INSTR word does not halt until Stall drops.
- DONE: PC, counters and outputs are frozen.
- Start in DONE:
  - PC <= START_ADDR
  - both counters cleared
  - go to RUN
- Start while in RUN is ignored.
- Start in IDLE loads PC <= START_ADDR and clears both counters (they are already zero after Reset).
- CycleCount increments every RUN cycle, including stalled cycles and the halt cycle.
- InstrCount increments on non-stalled, non-halt RUN cycles.
- Both counters saturate at 2^CNT_W-1; they do not wrap.
- Reset has priority over everything, including Start in the same cycle. It aborts RUN mid-program.

## Timing
- Reset values: InstrAddr=START_ADDR, Running=0, Done=0, CycleCount=0, InstrCount=0, Instruction=9'h000.
- InstrAddr is a register output. Instruction is combinational from InstrIn, gated by Running. One instruction retires per cycle, with no branch delay slot.
- Start sampled at edge N: Running=1 from cycle N+1, with InstrAddr=START_ADDR.
- Jump or taken branch at edge N: InstrAddr=Target in cycle N+1. There is no bubble.
- HALT_INSTR fetched in cycle N: Done=1 and Running=0 from N+1. InstrAddr stays at the halt address.
- Stall is sampled each edge. There is no minimum or maximum stall length.

## Test plan
- Reset then Start, ROM holding 5 plain ops then HALT at 5:
  - InstrAddr steps 0,1,2,3,4,5.
  - Done=1 one cycle after PC=5.
  - InstrCount=5, CycleCount=6, InstrAddr stays 5.
- Jump at PC=3 with Target=40: next InstrAddr=40.
- Branch at PC=7:
  - BranchEn=1, Taken=0, Target=2: next PC=8.
  - Repeat with Taken=1: next PC=2.
  - Taken=1 with BranchEn=0: PC+1.
- Stall held 3 cycles at PC=12:
  - InstrAddr stays 12.
  - CycleCount +3, InstrCount +0.
  - HALT word under Stall does not set Done until Stall=0.
- Wrap and saturation:
  - PC=1023 (PC_W=10) advances to 0.
  - With CNT_W=4, a 20-cycle run leaves CycleCount=15.
- Reset asserted mid-RUN at PC=9 together with Start:
  - Next cycle is IDLE with InstrAddr=START_ADDR and counters 0.
  - A subsequent Start restarts the program.
  - Start issued in DONE restarts from START_ADDR with counters cleared.
